fazyrv_shftregfile: RTL

FAZYRV_SHFTREGFILE -- requirements
Module: fazyrv_shftregfile

---
 rtl/fazyrv_shftregfile_pkg.sv | 18 +
 rtl/fazyrv_shftreg_rot.sv | 37 +++
 rtl/fazyrv_shftregfile.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fazyrv_shftregfile_pkg.sv
// ----------------------------------------------------------------------------
// fazyrv_shftregfile_pkg
// Shared types and helpers for the chunk-serial shift register file.
//   state_e      : pass FSM state (IDLE / SHIFT)
//   calc_nchunk  : number of chunks making up one register (XLEN/CHUNKSIZE)
// ----------------------------------------------------------------------------
package fazyrv_shftregfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int calc_nchunk(input int xlen, input int chunksize);
        return xlen / chunksize;
    endfunction

endpackage

// File: rtl/fazyrv_shftreg_rot.sv
// ----------------------------------------------------------------------------
// fazyrv_shftreg_rot
// One architectural register stored as a right-shifting chunk register.
//   clk_i  : clock
//   shft_i : shift right by one chunk this cycle
//   rot_i  : 1 = LSB chunk re-enters at the MSB, 0 = dat_i enters at the MSB
//   dat_i  : new chunk for the MSB when not rotating
//   dat_o  : current LSB chunk
// Storage is deliberately not reset.
// ----------------------------------------------------------------------------
module fazyrv_shftreg_rot #(
    parameter int CHUNKSIZE = 2,
    parameter int XLEN      = 32
) (
    input  logic                 clk_i,
    input  logic                 shft_i,
    input  logic                 rot_i,
    input  logic [CHUNKSIZE-1:0] dat_i,
    output logic [CHUNKSIZE-1:0] dat_o
);

    logic [XLEN-1:0]      reg_q;
    logic [XLEN-1:0]      reg_d;
    logic [CHUNKSIZE-1:0] msb_in;

    assign msb_in = rot_i ? reg_q[CHUNKSIZE-1:0] : dat_i;
    assign reg_d  = {msb_in, reg_q[XLEN-1:CHUNKSIZE]};

    always_ff @(posedge clk_i) begin
        if (shft_i) begin
            reg_q <= reg_d;
        end
    end

    assign dat_o = reg_q[CHUNKSIZE-1:0];

endmodule

// File: rtl/fazyrv_shftregfile.sv
// ----------------------------------------------------------------------------
// fazyrv_shftregfile
// Chunk-serial register file. A start pulse latches rs1/rs2/rd/we and runs
// one pass of XLEN/CHUNKSIZE shift cycles; addressed source registers rotate
// (unchanged after the pass), the destination takes dat_i at its MSB.
//   clk_i, rst_i      : clock, async active-high reset
//   start_i           : launch a pass (ignored while busy)
//   stall_i           : freeze the pass for this cycle
//   rs1_i/rs2_i/rd_i  : addresses, sampled at start
//   we_i              : write enable for rd, sampled at start
//   dat_i             : write chunk, LSB chunk first
//   rs1_o/rs2_o       : read chunks, LSB chunk first, 0 when idle
//   busy_o            : pass in progress
//   done_o            : one-cycle pulse in the first idle cycle after a pass
// ----------------------------------------------------------------------------
module fazyrv_shftregfile
    import fazyrv_shftregfile_pkg::*;
#(
    parameter int CHUNKSIZE = 2,
    parameter int XLEN      = 32,
    parameter int NREGS     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stall_i,
    input  logic [$clog2(NREGS)-1:0]   rs1_i,
    input  logic [$clog2(NREGS)-1:0]   rs2_i,
    input  logic [$clog2(NREGS)-1:0]   rd_i,
    input  logic                       we_i,
    input  logic [CHUNKSIZE-1:0]       dat_i,
    output logic [CHUNKSIZE-1:0]       rs1_o,
    output logic [CHUNKSIZE-1:0]       rs2_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int NCHUNK = calc_nchunk(XLEN, CHUNKSIZE);
    localparam int CW     = $clog2(NCHUNK);
    localparam int AW     = $clog2(NREGS);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [AW-1:0]   rs1_q,   rs1_d;
    logic [AW-1:0]   rs2_q,   rs2_d;
    logic [AW-1:0]   rd_q,    rd_d;
    logic            we_q,    we_d;
    logic            done_q,  done_d;
    logic            shift_en;

    // ------------------------------------------------------------------
    // Pass FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        we_d    = we_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    rd_d    = rd_i;
                    we_d    = we_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!stall_i) begin
                    cnt_d = cnt_q + CW'(1);
                    // Last chunk shifted on this edge; done appears in IDLE.
                    if (cnt_q == CW'(NCHUNK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_en = (state_q == SHIFT) && !stall_i;

    // ------------------------------------------------------------------
    // Storage: x0 has none and reads as zero, so writes to it vanish.
    // ------------------------------------------------------------------
    logic [NREGS-1:0][CHUNKSIZE-1:0] lsb_chunk;

    assign lsb_chunk[0] = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(r);
        logic hit_rd;
        logic shft;

        assign hit_rd = we_q && (rd_q == IDX);
        // OR of the hits: a register named twice still shifts only once.
        assign shft   = shift_en && ((rs1_q == IDX) || (rs2_q == IDX) || hit_rd);

        fazyrv_shftreg_rot #(
            .CHUNKSIZE (CHUNKSIZE),
            .XLEN      (XLEN)
        ) u_reg (
            .clk_i  (clk_i),
            .shft_i (shft),
            .rot_i  (!hit_rd),
            .dat_i  (dat_i),
            .dat_o  (lsb_chunk[r])
        );
    end

    // Reads come from the LSB before the edge, so rd==rs gives old data.
    assign rs1_o  = (state_q == SHIFT) ? lsb_chunk[rs1_q] : '0;
    assign rs2_o  = (state_q == SHIFT) ? lsb_chunk[rs2_q] : '0;
    assign busy_o = (state_q == SHIFT);
    assign done_o = done_q;

endmodule
